// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: clock divider, horizontal/vertical counters,
// registered sync/blanking decode, tick pulses and a completed-frame counter.
module vga_timing_gen #(
   parameter int CLK_DIV     = 4,
   parameter int H_TOTAL     = 800,
   parameter int H_SYNC      = 96,
   parameter int H_VIS_START = 144,
   parameter int H_VIS_END   = 783,
   parameter int V_TOTAL     = 525,
   parameter int V_SYNC      = 2,
   parameter int V_VIS_START = 35,
   parameter int V_VIS_END   = 514
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic        hSync,
   output logic        vSync,
   output logic        bright,
   output logic [9:0]  hCount,
   output logic [9:0]  vCount,
   output logic        pixTick,
   output logic        lineTick,
   output logic        frameTick,
   output logic [15:0] frameCount
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

   logic [DIV_W-1:0] r_div_p0;
   logic [9:0]       r_hcnt_p0;
   logic [9:0]       r_vcnt_p0;
   logic [15:0]      r_frame_p0;
   logic             r_hsync_p0;
   logic             r_vsync_p0;
   logic             r_bright_p0;

   logic [DIV_W-1:0] w_div_nxt;
   logic [9:0]       w_hcnt_nxt;
   logic [9:0]       w_vcnt_nxt;
   logic             w_pix;
   logic             w_line;
   logic             w_frame;

   // Sync outputs are active-low: high once the counter leaves the sync band.
   function automatic logic f_sync_n(input logic [9:0] cnt, input logic [9:0] width);
      return !(cnt < width);
   endfunction

   function automatic logic f_bright(input logic [9:0] h, input logic [9:0] v);
      return (h >= 10'(H_VIS_START)) && (h <= 10'(H_VIS_END)) &&
             (v >= 10'(V_VIS_START)) && (v <= 10'(V_VIS_END));
   endfunction

   // Ticks are gated by rst_n so they drop immediately, even with CLK_DIV=1.
   always_comb begin
      w_pix   = rst_n & en & (r_div_p0 == DIV_MAX);
      w_line  = w_pix & (r_hcnt_p0 == H_LAST);
      w_frame = w_line & (r_vcnt_p0 == V_LAST);
   end

   always_comb begin
      w_div_nxt  = r_div_p0;
      w_hcnt_nxt = r_hcnt_p0;
      w_vcnt_nxt = r_vcnt_p0;
      if (en) begin
         w_div_nxt = (r_div_p0 == DIV_MAX) ? '0 : r_div_p0 + 1'b1;
      end
      if (w_pix) begin
         w_hcnt_nxt = (r_hcnt_p0 == H_LAST) ? '0 : r_hcnt_p0 + 10'd1;
      end
      if (w_line) begin
         w_vcnt_nxt = (r_vcnt_p0 == V_LAST) ? '0 : r_vcnt_p0 + 10'd1;
      end
   end

   // Stage p0: counters plus decode of their next values, so sync and
   // bright switch on the very edge the counts change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div_p0    <= '0;
         r_hcnt_p0   <= '0;
         r_vcnt_p0   <= '0;
         r_frame_p0  <= '0;
         r_hsync_p0  <= 1'b0;
         r_vsync_p0  <= 1'b0;
         r_bright_p0 <= 1'b0;
      end else if (en) begin
         r_div_p0    <= w_div_nxt;
         r_hcnt_p0   <= w_hcnt_nxt;
         r_vcnt_p0   <= w_vcnt_nxt;
         r_hsync_p0  <= f_sync_n(w_hcnt_nxt, 10'(H_SYNC));
         r_vsync_p0  <= f_sync_n(w_vcnt_nxt, 10'(V_SYNC));
         r_bright_p0 <= f_bright(w_hcnt_nxt, w_vcnt_nxt);
         if (w_frame) begin
            r_frame_p0 <= r_frame_p0 + 16'd1;
         end
      end
   end

   assign hSync      = r_hsync_p0;
   assign vSync      = r_vsync_p0;
   assign bright     = r_bright_p0;
   assign hCount     = r_hcnt_p0;
   assign vCount     = r_vcnt_p0;
   assign pixTick    = w_pix;
   assign lineTick   = w_line;
   assign frameTick  = w_frame;
   assign frameCount = r_frame_p0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-parameter instance for reset, line, hold and async
// reset behaviour; a tiny-raster instance for wrap, frame and enable gating.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, en;
   logic        d_hSync, d_vSync, d_bright, d_pixTick, d_lineTick, d_frameTick;
   logic [9:0]  d_hCount, d_vCount;
   logic [15:0] d_frameCount;

   logic        s_rst_n, s_en;
   logic        s_hSync, s_vSync, s_bright, s_pixTick, s_lineTick, s_frameTick;
   logic [9:0]  s_hCount, s_vCount;
   logic [15:0] s_frameCount;

   int total = 0;
   int bad   = 0;

   vga_timing_gen u_dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .hSync(d_hSync), .vSync(d_vSync), .bright(d_bright),
      .hCount(d_hCount), .vCount(d_vCount),
      .pixTick(d_pixTick), .lineTick(d_lineTick), .frameTick(d_frameTick),
      .frameCount(d_frameCount)
   );

   vga_timing_gen #(
      .CLK_DIV(1), .H_TOTAL(8), .H_SYNC(2), .H_VIS_START(3), .H_VIS_END(6),
      .V_TOTAL(4), .V_SYNC(1), .V_VIS_START(1), .V_VIS_END(2)
   ) u_small (
      .clk(clk), .rst_n(s_rst_n), .en(s_en),
      .hSync(s_hSync), .vSync(s_vSync), .bright(s_bright),
      .hCount(s_hCount), .vCount(s_vCount),
      .pixTick(s_pixTick), .lineTick(s_lineTick), .frameTick(s_frameTick),
      .frameCount(s_frameCount)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      int found, hs_low, hs_high, lt_cnt, br_cnt, viol;
      int eh, ev, ef, br_frame;

      rst_n = 1'b0; en = 1'b1;
      s_rst_n = 1'b0; s_en = 1'b1;
      repeat (3) tick();

      // Reset state
      check("rst_hCount", d_hCount, 0);
      check("rst_vCount", d_vCount, 0);
      check("rst_frameCount", d_frameCount, 0);
      check("rst_hSync", d_hSync, 0);
      check("rst_vSync", d_vSync, 0);
      check("rst_bright", d_bright, 0);
      check("rst_pixTick", d_pixTick, 0);
      check("rst_small_pixTick", s_pixTick, 0);
      check("rst_small_lineTick", s_lineTick, 0);

      // Reset release: pixTick on the 4th clk, hCount 0->1 on that edge
      rst_n = 1'b1;
      tick();
      check("rel_e1_pixTick", d_pixTick, 0);
      tick();
      check("rel_e2_pixTick", d_pixTick, 0);
      tick();
      check("rel_e3_pixTick", d_pixTick, 1);
      check("rel_e3_hCount", d_hCount, 0);
      tick();
      check("rel_e4_hCount", d_hCount, 1);
      check("rel_e4_pixTick", d_pixTick, 0);
      check("rel_e4_hSync", d_hSync, 0);
      check("rel_e4_bright", d_bright, 0);

      // Line timing across one full line
      found = 0;
      for (int i = 0; i < 4000 && found == 0; i++) begin
         tick();
         if (d_lineTick === 1'b1) found = 1;
      end
      check("wait_lineTick", found, 1);
      check("line0_hCount", d_hCount, 799);
      hs_low = 0; hs_high = 0; lt_cnt = 0; br_cnt = 0;
      for (int i = 0; i < 3200; i++) begin
         tick();
         if (d_hSync === 1'b0) hs_low++; else hs_high++;
         if (d_lineTick === 1'b1) lt_cnt++;
         if (d_bright === 1'b1) br_cnt++;
      end
      check("line_hsync_low_clks", hs_low, 384);
      check("line_hsync_high_clks", hs_high, 2816);
      check("line_tick_count", lt_cnt, 1);
      check("line_tick_period_end", d_lineTick, 1);
      check("line_bright_invisible", br_cnt, 0);
      check("line1_vCount", d_vCount, 1);
      check("line1_vSync", d_vSync, 0);
      tick();
      check("line2_vCount", d_vCount, 2);
      check("line2_vSync", d_vSync, 1);
      check("line2_hSync", d_hSync, 0);

      // Enable hold at hCount=500
      found = 0;
      for (int i = 0; i < 4000 && found == 0; i++) begin
         tick();
         if (d_hCount === 10'd500) found = 1;
      end
      check("wait_h500", found, 1);
      en = 1'b0;
      viol = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (d_pixTick !== 1'b0 || d_lineTick !== 1'b0 || d_frameTick !== 1'b0 ||
             d_hCount !== 10'd500 || d_vCount !== 10'd2 || d_hSync !== 1'b1 ||
             d_vSync !== 1'b1 || d_bright !== 1'b0 || d_frameCount !== 16'd0)
            viol++;
      end
      check("hold_violations", viol, 0);
      en = 1'b1;
      repeat (3) tick();
      check("resume_e3_hCount", d_hCount, 500);
      tick();
      check("resume_e4_hCount", d_hCount, 501);

      // Asynchronous reset between edges
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_hCount", d_hCount, 0);
      check("arst_vCount", d_vCount, 0);
      check("arst_hSync", d_hSync, 0);
      check("arst_vSync", d_vSync, 0);
      check("arst_bright", d_bright, 0);
      check("arst_pixTick", d_pixTick, 0);
      tick();
      rst_n = 1'b1;
      repeat (4) tick();
      check("arst_restart_hCount", d_hCount, 1);
      check("arst_restart_vCount", d_vCount, 0);

      // Tiny raster: 8x4, one clk per pixel
      s_rst_n = 1'b1;
      #1;
      check("s_rel_pixTick", s_pixTick, 1);
      check("s_rel_hCount", s_hCount, 0);
      br_frame = 0;
      for (int k = 1; k <= 95; k++) begin
         tick();
         eh = k % 8;
         ev = (k / 8) % 4;
         ef = k / 32;
         check($sformatf("s_k%0d_hCount", k), s_hCount, eh);
         check($sformatf("s_k%0d_vCount", k), s_vCount, ev);
         check($sformatf("s_k%0d_frameCount", k), s_frameCount, ef);
         check($sformatf("s_k%0d_hSync", k), s_hSync, (eh < 2) ? 0 : 1);
         check($sformatf("s_k%0d_vSync", k), s_vSync, (ev < 1) ? 0 : 1);
         check($sformatf("s_k%0d_bright", k), s_bright,
               (eh >= 3 && eh <= 6 && ev >= 1 && ev <= 2) ? 1 : 0);
         check($sformatf("s_k%0d_lineTick", k), s_lineTick, (eh == 7) ? 1 : 0);
         check($sformatf("s_k%0d_frameTick", k), s_frameTick,
               (eh == 7 && ev == 3) ? 1 : 0);
         if (k >= 33 && k <= 64 && s_bright === 1'b1) br_frame++;
      end
      check("s_bright_per_frame", br_frame, 8);

      // Enable low while sitting on the frame's last pixel
      s_en = 1'b0;
      #1;
      check("s_hold_pixTick", s_pixTick, 0);
      check("s_hold_lineTick", s_lineTick, 0);
      check("s_hold_frameTick", s_frameTick, 0);
      repeat (5) tick();
      check("s_hold_hCount", s_hCount, 7);
      check("s_hold_vCount", s_vCount, 3);
      check("s_hold_frameCount", s_frameCount, 2);
      check("s_hold_hSync", s_hSync, 1);
      s_en = 1'b1;
      #1;
      check("s_resume_frameTick", s_frameTick, 1);
      tick();
      check("s_wrap_hCount", s_hCount, 0);
      check("s_wrap_vCount", s_vCount, 0);
      check("s_wrap_frameCount", s_frameCount, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter CLK_DIV, default 4: system clocks per pixel. 100 MHz clk gives a 25 MHz pixel rate.
REQ-002 Parameter H_TOTAL, default 800: pixels per line, including blanking.
REQ-003 Parameter H_SYNC, default 96: hCount values 0..H_SYNC-1 have hSync asserted.
REQ-004 Parameters H_VIS_START, default 144, and H_VIS_END, default 783: first and last visible hCount.
REQ-005 Parameter V_TOTAL, default 525: lines per frame.
REQ-006 Parameter V_SYNC, default 2: vCount values 0..V_SYNC-1 have vSync asserted.
REQ-007 Parameters V_VIS_START, default 35, and V_VIS_END, default 514: first and last visible vCount.
REQ-008 clk  input  1  system clock; all state changes on its rising edge.
REQ-009 rst_n  input  1  reset, asynchronous, active-low.
REQ-010 en  input  1  run enable; all timing state holds while low.
REQ-011 hSync  output  1  horizontal sync, active-low.
REQ-012 vSync  output  1  vertical sync, active-low.
REQ-013 bright  output  1  high inside the visible window.
REQ-014 hCount  output  10  raw horizontal pixel counter, 0..H_TOTAL-1.
REQ-015 vCount  output  10  raw vertical line counter, 0..V_TOTAL-1.
REQ-016 pixTick  output  1  one-clk pulse per pixel advance.
REQ-017 lineTick  output  1  one-clk pulse on the last pixel of each line.
REQ-018 frameTick  output  1  one-clk pulse on the last pixel of each frame.
REQ-019 frameCount  output  16  frames completed since reset.

Function
REQ-020 Divider counter:
- range 0..CLK_DIV-1; increments each clk while en=1; wraps to 0.
- pixTick=1 exactly when en=1 and divider==CLK_DIV-1.
- with CLK_DIV=1, pixTick=en.
REQ-021 hCount:
- increments by 1 on each clk edge where pixTick=1.
- at H_TOTAL-1 it wraps to 0 instead.
REQ-022 vCount:
- increments only on the edge where hCount wraps.
- at V_TOTAL-1 it wraps to 0 on that same edge.
REQ-023 Tick pulses:
- lineTick = pixTick AND hCount==H_TOTAL-1.
- frameTick = lineTick AND vCount==V_TOTAL-1.
- both are combinational from current state; no added latency.
REQ-024 frameCount increments on each edge where frameTick=1; wraps FFFF->0000.
REQ-025 hSync, vSync and bright are registered from the next-state counter values, so they change on the same edge as hCount/vCount. There is zero skew between counts and sync/bright.
REQ-026 Decode rules:
- hSync=0 iff hCount<H_SYNC.
- vSync=0 iff vCount<V_SYNC.
- bright=1 iff H_VIS_START<=hCount<=H_VIS_END and V_VIS_START<=vCount<=V_VIS_END.
- all comparisons unsigned.
REQ-027 While en=0:
- divider, hCount, vCount, frameCount, hSync, vSync and bright hold.
- pixTick, lineTick and frameTick are 0.
REQ-028 When en rises, counting resumes from the held divider value; there are no skipped or duplicated pixels.
REQ-029 Counters never take values at or above H_TOTAL/V_TOTAL. A frame is exactly H_TOTAL*V_TOTAL*CLK_DIV enabled clocks.

Reset
REQ-030 While rst_n=0, without waiting for clk:
- divider, hCount, vCount and frameCount are 0.
- hSync=0, vSync=0, bright=0.
- pixTick, lineTick and frameTick are 0.
REQ-031 Reset asserted mid-frame discards all position state; the next frame starts from hCount=0, vCount=0.
REQ-032 Reset release is synchronized by the instantiating top. The first counting edge is the first clk edge with rst_n=1 and en=1.

Verification
REQ-033 Reset release:
- stimulus: rst_n release with en=1, default parameters.
- response: pixTick first high on the 4th clk; hCount 0->1 on that edge.
- hSync low and bright low throughout.
REQ-034 Line timing:
- lineTick period 3200 clk.
- hSync low for 384 clk per line.
- bright high for 2560 clk per visible line, starting when hCount becomes 144.
REQ-035 Frame timing:
- frameTick period 1,680,000 clk.
- vSync low for 6400 clk per frame.
- exactly 307,200 pixTicks with bright=1 per frame.
- frameCount 0->1 at the first frameTick.
REQ-036 Enable hold:
- stimulus: en=0 at hCount=500 for 100 clk.
- response: all counts and outputs frozen; no ticks.
- after en=1, hCount reaches 501 within 4 clk.
REQ-037 Asynchronous reset:
- stimulus: rst_n pulsed low between clk edges at vCount=300.
- response: all outputs 0 before the next edge.
REQ-038 Wrap boundaries:
- stimulus: run with H_TOTAL=8, V_TOTAL=4, CLK_DIV=1.
- response: hCount 7->0 and vCount 3->0 on the same edge.
- lineTick and frameTick coincide on that edge.
